// File: rtl/extclk_pkg.sv
// Shared definitions for the external-clock supervisor: state codes,
// default timing parameters and bus widths.
package extclk_pkg;

  localparam int unsigned RST_LEN_DEF    = 16;
  localparam int unsigned SETTLE_LEN_DEF = 4096;
  localparam int unsigned WIN_BITS_DEF   = 16;
  localparam int unsigned MIN_EDGES_DEF  = 60;
  localparam int unsigned MAX_EDGES_DEF  = 68;

  localparam int unsigned EDGE_BITS = 12;
  localparam int unsigned FAIL_BITS = 8;
  localparam int unsigned CLEAR_LEN = 4;
  localparam int unsigned STATE_BITS = 3;

  typedef enum logic [STATE_BITS-1:0] {
    ST_IDLE    = 3'd0,
    ST_DCMRST  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_CLEAR   = 3'd4,
    ST_RUN     = 3'd5
  } state_t;

  // Inclusive range test of a window edge count.
  function automatic logic edges_in_range(input logic [EDGE_BITS-1:0] n,
                                          input int unsigned lo,
                                          input int unsigned hi);
    return (32'(n) >= lo) && (32'(n) <= hi);
  endfunction

endpackage

// File: rtl/edge_window_counter.sv
// Synchronises the external counter tick, detects both edge polarities and
// counts them over back-to-back windows of 2^WIN_BITS clk cycles.
//   clk, reset      : clock, async active-high reset
//   clear           : hold window and edge counters at zero
//   ext_tick        : asynchronous external counter bit
//   win_done_c      : high in the last cycle of each window
//   edge_total_c    : edge count of the window, including this cycle's edge
module edge_window_counter
  import extclk_pkg::*;
#(
  parameter int unsigned WIN_BITS = WIN_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 ext_tick,
  output logic                 win_done_c,
  output logic [EDGE_BITS-1:0] edge_total_c
);

  logic [1:0]           sync_q;
  logic                 prev_q;
  logic                 tick_edge_c;
  logic [WIN_BITS-1:0]  win_cnt_q;
  logic [EDGE_BITS-1:0] edge_cnt_q;

  // Two-flop synchroniser plus one delayed sample for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], ext_tick};
      prev_q <= sync_q[1];
    end
  end

  assign tick_edge_c = sync_q[1] ^ prev_q;

  // An edge in the closing cycle belongs to the closing window; saturate at all-ones.
  assign edge_total_c = (tick_edge_c && (edge_cnt_q != '1))
                        ? edge_cnt_q + EDGE_BITS'(1) : edge_cnt_q;
  assign win_done_c   = ~clear && (win_cnt_q == '1);

  // Window and edge counters; the next window restarts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
    end else if (clear) begin
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
    end else begin
      win_cnt_q  <= win_cnt_q + WIN_BITS'(1);
      edge_cnt_q <= win_done_c ? '0 : edge_total_c;
    end
  end

endmodule

// File: rtl/extclk_supervisor.sv
// Supervises an external-frequency DCM: pulses its reset, waits for it to
// settle, checks the external tick rate over measurement windows and keeps
// checking while locked.
//   clk, reset       : clock, async active-high reset
//   enable           : supervision active while high
//   restart          : one-cycle pulse forcing a new DCM reset sequence
//   ext_tick         : asynchronous external counter bit
//   dcmreset         : DCM reset
//   cnt_reset        : external counter reset
//   cnt_inhibit      : external counter inhibit
//   locked           : high only in RUN
//   state            : current state code
//   last_edges       : edge count of the last completed window
//   fail_cnt         : saturating count of lock losses
module extclk_supervisor
  import extclk_pkg::*;
#(
  parameter int unsigned RST_LEN    = RST_LEN_DEF,
  parameter int unsigned SETTLE_LEN = SETTLE_LEN_DEF,
  parameter int unsigned WIN_BITS   = WIN_BITS_DEF,
  parameter int unsigned MIN_EDGES  = MIN_EDGES_DEF,
  parameter int unsigned MAX_EDGES  = MAX_EDGES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  restart,
  input  logic                  ext_tick,
  output logic                  dcmreset,
  output logic                  cnt_reset,
  output logic                  cnt_inhibit,
  output logic                  locked,
  output logic [STATE_BITS-1:0] state,
  output logic [EDGE_BITS-1:0]  last_edges,
  output logic [FAIL_BITS-1:0]  fail_cnt
);

  localparam int unsigned DWELL_A   = (RST_LEN > SETTLE_LEN) ? RST_LEN : SETTLE_LEN;
  localparam int unsigned DWELL_MAX = (DWELL_A > CLEAR_LEN) ? DWELL_A : CLEAR_LEN;
  localparam int unsigned DW        = ($clog2(DWELL_MAX) > 0) ? $clog2(DWELL_MAX) : 1;

  state_t               state_q, state_d;
  logic [DW-1:0]        dwell_q, dwell_d;
  logic [EDGE_BITS-1:0] last_d;
  logic [FAIL_BITS-1:0] fail_d;
  logic                 dcmreset_d, cnt_reset_d, cnt_inhibit_d, locked_d;
  logic                 win_clear_c;
  logic                 win_done_c;
  logic [EDGE_BITS-1:0] edge_total_c;
  logic                 win_ok_c;

  // Windows are held at zero until MEASURE starts, then run back-to-back.
  assign win_clear_c = (state_q == ST_IDLE) || (state_q == ST_DCMRST) ||
                       (state_q == ST_SETTLE);

  edge_window_counter #(
    .WIN_BITS (WIN_BITS)
  ) u_ewc (
    .clk          (clk),
    .reset        (reset),
    .clear        (win_clear_c),
    .ext_tick     (ext_tick),
    .win_done_c   (win_done_c),
    .edge_total_c (edge_total_c)
  );

  assign win_ok_c = edges_in_range(edge_total_c, MIN_EDGES, MAX_EDGES);

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dwell_q     <= '0;
      dcmreset    <= 1'b0;
      cnt_reset   <= 1'b0;
      cnt_inhibit <= 1'b1;
      locked      <= 1'b0;
      last_edges  <= '0;
      fail_cnt    <= '0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      dcmreset    <= dcmreset_d;
      cnt_reset   <= cnt_reset_d;
      cnt_inhibit <= cnt_inhibit_d;
      locked      <= locked_d;
      last_edges  <= last_d;
      fail_cnt    <= fail_d;
    end
  end

  assign state = state_q;

  // Next state; later overrides give enable=0 > restart > window result.
  always_comb begin
    state_d       = state_q;
    dwell_d       = '0;
    last_d        = last_edges;
    fail_d        = fail_cnt;
    dcmreset_d    = 1'b0;
    cnt_reset_d   = 1'b0;
    cnt_inhibit_d = 1'b1;
    locked_d      = 1'b0;

    if (win_done_c && ((state_q == ST_MEASURE) || (state_q == ST_RUN))) begin
      last_d = edge_total_c;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_DCMRST;
      end
      ST_DCMRST: begin
        if (dwell_q == DW'(RST_LEN - 1)) state_d = ST_SETTLE;
        else                             dwell_d = dwell_q + DW'(1);
      end
      ST_SETTLE: begin
        if (dwell_q == DW'(SETTLE_LEN - 1)) state_d = ST_MEASURE;
        else                                dwell_d = dwell_q + DW'(1);
      end
      ST_MEASURE: begin
        if (win_done_c) state_d = win_ok_c ? ST_CLEAR : ST_DCMRST;
      end
      ST_CLEAR: begin
        if (dwell_q == DW'(CLEAR_LEN - 1)) state_d = ST_RUN;
        else                               dwell_d = dwell_q + DW'(1);
      end
      ST_RUN: begin
        if (win_done_c && !win_ok_c) begin
          state_d = ST_DCMRST;
          fail_d  = (fail_cnt == '1) ? fail_cnt : fail_cnt + FAIL_BITS'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (restart && (state_q != ST_IDLE)) begin
      state_d = ST_DCMRST;
      dwell_d = '0;
      fail_d  = fail_cnt;
    end

    if (!enable) begin
      state_d = ST_IDLE;
      dwell_d = '0;
      fail_d  = fail_cnt;
    end

    // Outputs follow the state being entered.
    case (state_d)
      ST_DCMRST: dcmreset_d = 1'b1;
      ST_CLEAR:  cnt_reset_d = 1'b1;
      ST_RUN: begin
        cnt_inhibit_d = 1'b0;
        locked_d      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_extclk_supervisor.sv
// Directed bench for extclk_supervisor with shortened timing:
// RST_LEN=16, SETTLE_LEN=16, 64-cycle windows, accept 30..34 edges.
// A tick toggling every 2 cycles gives 32 edges/window, every cycle gives 64.
module tb_extclk_supervisor;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DCMRST  = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_MEASURE = 3'd3;
  localparam logic [2:0] S_CLEAR   = 3'd4;
  localparam logic [2:0] S_RUN     = 3'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        restart;
  logic        ext_tick = 1'b0;
  logic        dcmreset;
  logic        cnt_reset;
  logic        cnt_inhibit;
  logic        locked;
  logic [2:0]  state;
  logic [11:0] last_edges;
  logic [7:0]  fail_cnt;

  int vectors = 0;
  int errors  = 0;
  int half    = 0;
  int ph      = 0;

  extclk_supervisor #(
    .RST_LEN    (16),
    .SETTLE_LEN (16),
    .WIN_BITS   (6),
    .MIN_EDGES  (30),
    .MAX_EDGES  (34)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .restart     (restart),
    .ext_tick    (ext_tick),
    .dcmreset    (dcmreset),
    .cnt_reset   (cnt_reset),
    .cnt_inhibit (cnt_inhibit),
    .locked      (locked),
    .state       (state),
    .last_edges  (last_edges),
    .fail_cnt    (fail_cnt)
  );

  always #4 clk = ~clk;

  // External tick source: toggles every 'half' cycles, stopped when half==0.
  always @(negedge clk) begin
    if (half == 0) ph = 0;
    else if (ph + 1 >= half) begin
      ext_tick = ~ext_tick;
      ph = 0;
    end else ph = ph + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (state === s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; restart = 1'b0;
    repeat (3) cyc();
    vectors++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE); end
    vectors++; if (dcmreset !== 1'b0) begin errors++; $display("FAIL reset_dcmreset: got %b expected 0", dcmreset); end
    vectors++; if (cnt_reset !== 1'b0) begin errors++; $display("FAIL reset_cnt_reset: got %b expected 0", cnt_reset); end
    vectors++; if (cnt_inhibit !== 1'b1) begin errors++; $display("FAIL reset_cnt_inhibit: got %b expected 1", cnt_inhibit); end
    vectors++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
    vectors++; if (last_edges !== 12'd0) begin errors++; $display("FAIL reset_last_edges: got %0d expected 0", last_edges); end
    vectors++; if (fail_cnt !== 8'd0) begin errors++; $display("FAIL reset_fail_cnt: got %0d expected 0", fail_cnt); end
    @(negedge clk) reset = 1'b0;
    cyc();
    vectors++; if (state !== S_IDLE) begin errors++; $display("FAIL idle_hold: got %0d expected %0d", state, S_IDLE); end
  endtask

  task automatic test_lock();
    int c;
    int hi;
    int clr;
    half = 2;
    repeat (8) cyc();
    @(negedge clk) enable = 1'b1;
    cyc();
    c = 0;
    vectors++; if (state !== S_DCMRST) begin errors++; $display("FAIL lock_enter_dcmrst: got %0d expected %0d", state, S_DCMRST); end
    hi = 0;
    while (dcmreset === 1'b1 && c < 200) begin
      hi++; cyc(); c++;
    end
    vectors++; if (hi !== 16) begin errors++; $display("FAIL lock_dcmreset_len: got %0d expected 16", hi); end
    vectors++; if (state !== S_SETTLE) begin errors++; $display("FAIL lock_settle: got %0d expected %0d", state, S_SETTLE); end
    vectors++; if (cnt_inhibit !== 1'b1) begin errors++; $display("FAIL lock_settle_inhibit: got %b expected 1", cnt_inhibit); end
    clr = 0;
    while (state !== S_RUN && c < 400) begin
      cyc(); c++;
      if (state === S_CLEAR && cnt_reset === 1'b1 && cnt_inhibit === 1'b1) clr++;
    end
    vectors++; if (c < 98 || c > 102) begin errors++; $display("FAIL lock_latency: got %0d expected 100", c); end
    vectors++; if (clr !== 4) begin errors++; $display("FAIL lock_clear_len: got %0d expected 4", clr); end
    vectors++; if (last_edges !== 12'd32) begin errors++; $display("FAIL lock_last_edges: got %0d expected 32", last_edges); end
    vectors++; if (locked !== 1'b1 || cnt_inhibit !== 1'b0 || cnt_reset !== 1'b0) begin
      errors++; $display("FAIL lock_outputs: got locked=%b inh=%b crst=%b expected 1 0 0", locked, cnt_inhibit, cnt_reset);
    end
    // One full RUN window at the nominal rate must keep the lock.
    repeat (64) cyc();
    vectors++; if (state !== S_RUN || last_edges !== 12'd32) begin
      errors++; $display("FAIL run_window: got state=%0d edges=%0d expected 5 32", state, last_edges);
    end
  endtask

  task automatic test_loss();
    bit ok;
    @(negedge clk) half = 0;
    wait_state(S_DCMRST, 200, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL loss_timeout: got state=%0d expected %0d", state, S_DCMRST); end
    vectors++; if (locked !== 1'b0 || dcmreset !== 1'b1) begin
      errors++; $display("FAIL loss_outputs: got locked=%b dcmrst=%b expected 0 1", locked, dcmreset);
    end
    vectors++; if (fail_cnt !== 8'd1) begin errors++; $display("FAIL loss_fail_cnt: got %0d expected 1", fail_cnt); end
    vectors++; if (last_edges >= 12'd30) begin errors++; $display("FAIL loss_edges: got %0d expected below 30", last_edges); end
    wait_state(S_MEASURE, 100, ok);
    wait_state(S_DCMRST, 100, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL silent_timeout: got state=%0d expected %0d", state, S_DCMRST); end
    vectors++; if (last_edges !== 12'd0) begin errors++; $display("FAIL silent_edges: got %0d expected 0", last_edges); end
    vectors++; if (fail_cnt !== 8'd1) begin errors++; $display("FAIL silent_fail_cnt: got %0d expected 1", fail_cnt); end
  endtask

  task automatic test_too_fast();
    bit ok;
    @(negedge clk) half = 1;
    for (int k = 0; k < 2; k++) begin
      wait_state(S_MEASURE, 100, ok);
      wait_state(S_DCMRST, 100, ok);
      vectors++; if (!ok) begin errors++; $display("FAIL fast_timeout: got state=%0d expected %0d", state, S_DCMRST); end
      vectors++; if (last_edges !== 12'd64) begin errors++; $display("FAIL fast_edges: got %0d expected 64", last_edges); end
      vectors++; if (fail_cnt !== 8'd1 || locked !== 1'b0) begin
        errors++; $display("FAIL fast_no_lock: got fail=%0d locked=%b expected 1 0", fail_cnt, locked);
      end
    end
  endtask

  task automatic test_priority();
    bit ok;
    @(negedge clk) half = 2;
    wait_state(S_RUN, 300, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL prio_lock_timeout: got state=%0d expected %0d", state, S_RUN); end
    @(negedge clk) begin enable = 1'b0; restart = 1'b1; end
    cyc();
    vectors++; if (state !== S_IDLE || cnt_inhibit !== 1'b1 || locked !== 1'b0 || dcmreset !== 1'b0) begin
      errors++; $display("FAIL prio_disable: got state=%0d inh=%b locked=%b dcmrst=%b expected 0 1 0 0",
                         state, cnt_inhibit, locked, dcmreset);
    end
    vectors++; if (fail_cnt !== 8'd1) begin errors++; $display("FAIL prio_fail_cnt: got %0d expected 1", fail_cnt); end
    @(negedge clk) begin enable = 1'b1; restart = 1'b0; end
    wait_state(S_RUN, 300, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL relock_timeout: got state=%0d expected %0d", state, S_RUN); end
    @(negedge clk) restart = 1'b1;
    cyc();
    @(negedge clk) restart = 1'b0;
    vectors++; if (state !== S_DCMRST || dcmreset !== 1'b1 || locked !== 1'b0 || fail_cnt !== 8'd1) begin
      errors++; $display("FAIL restart_run: got state=%0d dcmrst=%b locked=%b fail=%0d expected 1 1 0 1",
                         state, dcmreset, locked, fail_cnt);
    end
  endtask

  task automatic test_saturation();
    bit ok;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk) half = 2;
      wait_state(S_RUN, 300, ok);
      if (!ok) begin
        vectors++; errors++; $display("FAIL sat_lock_timeout: got state=%0d expected %0d", state, S_RUN);
        break;
      end
      @(negedge clk) half = 0;
      wait_state(S_DCMRST, 200, ok);
      if (!ok) begin
        vectors++; errors++; $display("FAIL sat_loss_timeout: got state=%0d expected %0d", state, S_DCMRST);
        break;
      end
      if (i == 0) begin
        vectors++; if (fail_cnt !== 8'd2) begin errors++; $display("FAIL sat_step: got %0d expected 2", fail_cnt); end
      end
    end
    vectors++; if (fail_cnt !== 8'd255) begin errors++; $display("FAIL sat_fail_cnt: got %0d expected 255", fail_cnt); end
  endtask

  task automatic test_async_reset();
    bit ok;
    @(negedge clk) half = 2;
    wait_state(S_MEASURE, 100, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL ar_measure_timeout: got state=%0d expected %0d", state, S_MEASURE); end
    repeat (10) cyc();
    #2 reset = 1'b1;
    #1;
    vectors++; if (state !== S_IDLE || fail_cnt !== 8'd0 || last_edges !== 12'd0) begin
      errors++; $display("FAIL ar_regs: got state=%0d fail=%0d edges=%0d expected 0 0 0", state, fail_cnt, last_edges);
    end
    vectors++; if (dcmreset !== 1'b0 || cnt_reset !== 1'b0 || cnt_inhibit !== 1'b1 || locked !== 1'b0) begin
      errors++; $display("FAIL ar_outputs: got dcmrst=%b crst=%b inh=%b locked=%b expected 0 0 1 0",
                         dcmreset, cnt_reset, cnt_inhibit, locked);
    end
    @(negedge clk) enable = 1'b0;
    repeat (2) cyc();
    @(negedge clk) reset = 1'b0;
    cyc();
    vectors++; if (state !== S_IDLE) begin errors++; $display("FAIL ar_release: got %0d expected %0d", state, S_IDLE); end
    @(negedge clk) enable = 1'b1;
    cyc();
    vectors++; if (state !== S_DCMRST || dcmreset !== 1'b1 || fail_cnt !== 8'd0) begin
      errors++; $display("FAIL ar_restart: got state=%0d dcmrst=%b fail=%0d expected 1 1 0", state, dcmreset, fail_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_loss();
    test_too_fast();
    test_priority();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/extclk_supervisor.md
EXTCLK_SUPERVISOR -- requirements
Module: extclk_supervisor

Interface
REQ-001 Parameter RST_LEN, 16, DCM reset pulse length in clk cycles.
REQ-002 Parameter SETTLE_LEN, 4096, wait after DCM reset release before the first measurement, clk cycles.
REQ-003 Parameter WIN_BITS, 16, measurement window = 2^WIN_BITS clk cycles.
REQ-004 Parameter MIN_EDGES, 60, and MAX_EDGES, 68, inclusive acceptable edge-count range per window.
REQ-005 clk  in  1  local 125 MHz clock; all logic on posedge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  level; supervision active when 1.
REQ-008 restart  in  1  one-cycle pulse; forces a new DCM reset sequence.
REQ-009 ext_tick  in  1  asynchronous; external-counter bit 10 (nominal period 2048 clk cycles).
REQ-010 dcmreset  out  1  drives the external-frequency DCM reset.
REQ-011 cnt_reset  out  1  drives the external-counter reset.
REQ-012 cnt_inhibit  out  1  drives the external-counter inhibit.
REQ-013 locked  out  1  1 only in RUN.
REQ-014 state  out  3  current state code.
REQ-015 last_edges  out  12  edge count of the last completed window.
REQ-016 fail_cnt  out  8  saturating count of lock losses.

Function
REQ-017 ext_tick SHALL pass a 2-FF synchronizer; an edge = synchronized value differing from its previous sample (both polarities count).
REQ-018 States: IDLE(0), DCMRST(1), SETTLE(2), MEASURE(3), CLEAR(4), RUN(5).
REQ-019 IDLE: dcmreset=0, cnt_inhibit=1, cnt_reset=0; enable=1 -> DCMRST next cycle.
REQ-020 DCMRST: dcmreset=1 for exactly RST_LEN cycles, cnt_inhibit=1, then -> SETTLE.
REQ-021 SETTLE: dcmreset=0, cnt_inhibit=1, SETTLE_LEN cycles, then -> MEASURE with window counter and edge counter cleared.
REQ-022 MEASURE: one full window; at window end last_edges is loaded; count within [MIN_EDGES,MAX_EDGES] -> CLEAR, else -> DCMRST.
REQ-023 CLEAR: cnt_reset=1, cnt_inhibit=1 for 4 cycles, then -> RUN.
REQ-024 RUN: cnt_reset=0, cnt_inhibit=0, locked=1; windows continue back-to-back with no gap; any out-of-range window -> DCMRST and fail_cnt +1.
REQ-025 Edge counter 12 bits, saturates at 4095; an edge in the window's last cycle counts in the closing window; the new window starts at 0.
REQ-026 fail_cnt saturates at 255; cleared only by reset.
REQ-027 enable=0 in any state -> IDLE next cycle, overriding all other transitions; fail_cnt not incremented.
REQ-028 restart=1 with enable=1 in any non-IDLE state -> DCMRST next cycle, no fail_cnt increment; restart in IDLE ignored.
REQ-029 Priority when simultaneous: enable=0 > restart > window result.
REQ-030 All outputs registered; an output change appears the cycle the state is entered.

Reset
REQ-031 On reset: state=IDLE, dcmreset=0, cnt_reset=0, cnt_inhibit=1, locked=0, last_edges=0, fail_cnt=0, synchronizer and all counters 0.
REQ-032 Deassertion takes effect at the next clk edge; no self-clearing output glitch during reset.

Structure
REQ-033 State codes and default parameter values SHALL live in a shared package extclk_pkg.
REQ-034 Synchronizer, edge detect, window counter and edge counter SHALL form sub-module edge_window_counter (outputs win_done pulse, edge count).

Verification
REQ-035 ext_tick period 2048, enable=1 -> dcmreset high 16 cycles, locked rises after 16+4096+65536+4 cycles (+-2), last_edges=64.
REQ-036 In RUN, stop ext_tick -> at next window end last_edges=0, locked=0, state=DCMRST, fail_cnt=1.
REQ-037 ext_tick period 1024 -> last_edges=128, never reaches RUN, fail_cnt stays 0, DCMRST repeats.
REQ-038 enable=0 and restart=1 in same cycle in RUN -> state=IDLE, cnt_inhibit=1, fail_cnt unchanged.
REQ-039 Force 256 lock losses -> fail_cnt=255; asynchronous reset mid-MEASURE -> all outputs at REQ-031 values immediately.
